// File: rtl/lane_move_pkg.sv
// Shared types and helpers for the lane move controller.
//   state_t : FSM states (IDLE, MOVING)
//   dir_t   : movement direction (DIR_L, DIR_R)
//   lane_x    : pixel X of a lane
//   can_move  : whether a step from a lane in a direction stays on the road
//   next_lane : neighbouring lane in a direction
package lane_move_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        MOVING = 1'b1
    } state_t;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_t;

    function automatic logic [7:0] lane_x(input logic [2:0] lane, input int x_origin,
                                          input int lane_width);
        return 8'(x_origin + int'(lane) * lane_width);
    endfunction

    function automatic logic can_move(input logic [2:0] lane, input dir_t dir,
                                      input int num_lanes);
        logic ok;
        if (dir == DIR_L) begin
            ok = (lane != 3'd0);
        end else begin
            ok = (int'(lane) < (num_lanes - 1));
        end
        return ok;
    endfunction

    function automatic logic [2:0] next_lane(input logic [2:0] lane, input dir_t dir);
        logic [2:0] nl;
        if (dir == DIR_L) begin
            nl = lane - 3'd1;
        end else begin
            nl = lane + 3'd1;
        end
        return nl;
    endfunction

endpackage

// File: rtl/lane_move_controller_if.sv
// Key inputs and position outputs of the lane move controller.
//   Enable, LeftIn, RightIn : driven by the game/debouncer side (master)
//   Lane, PosX, Moving, MoveDone, Blocked : driven by the controller (slave)
interface lane_move_controller_if;
    logic       Enable;
    logic       LeftIn;
    logic       RightIn;
    logic [2:0] Lane;
    logic [7:0] PosX;
    logic       Moving;
    logic       MoveDone;
    logic       Blocked;

    modport master (
        output Enable, LeftIn, RightIn,
        input  Lane, PosX, Moving, MoveDone, Blocked
    );

    modport slave (
        input  Enable, LeftIn, RightIn,
        output Lane, PosX, Moving, MoveDone, Blocked
    );
endinterface

// File: rtl/frame_tick_gen.sv
// Frame tick generator: free-running counter 0..TICK_DIV-1 while Enable.
//   Clock, Reset (sync, active-high), Enable (low holds the count)
//   Tick : high in the cycle the counter sits at TICK_DIV-1
module frame_tick_gen #(
    parameter int TICK_DIV = 833333
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    output logic Tick
);
    localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_r;

    // Cycle counter; wraps after the tick cycle, frozen while disabled.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_r <= {CW{1'b0}};
        end else if (Enable) begin
            if (count_r == LAST_C) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign Tick = Enable && (count_r == LAST_C);

endmodule

// File: rtl/lane_move_controller.sv
// Lane move controller: edge-detects debounced left/right keys, moves the
// character one lane at a time and animates PosX by STEP_PX per frame tick.
//   Clock, Reset : system clock, synchronous active-high reset
//   ifc.Enable/LeftIn/RightIn : game running flag and key levels
//   ifc.Lane/PosX            : settled lane index and character pixel X
//   ifc.Moving/MoveDone/Blocked : motion flag, arrival pulse, rejected-press pulse
// Optional feature macro MOVE_QUEUE_EN: one-entry press queue during a move.
module lane_move_controller
    import lane_move_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int START_LANE = 1,
    parameter int X_ORIGIN   = 16,
    parameter int LANE_WIDTH = 40,
    parameter int STEP_PX    = 4,
    parameter int TICK_DIV   = 833333
) (
    input  logic                   Clock,
    input  logic                   Reset,
    lane_move_controller_if.slave  ifc
);
    localparam logic [2:0] START_LANE_C = 3'(START_LANE);
    localparam logic [7:0] START_X_C    = 8'(X_ORIGIN + START_LANE * LANE_WIDTH);
    localparam logic [7:0] STEP_C       = 8'(STEP_PX);

    state_t     state_r, state_nxt;
    dir_t       dir_r, dir_nxt;
    logic [2:0] lane_r, lane_nxt;
    logic [2:0] target_r, target_nxt;
    logic [7:0] pos_r, pos_nxt;
    logic       moving_r;
    logic       done_r, done_nxt;
    logic       blocked_r, blocked_nxt;
    logic       left_q_r, right_q_r;

    logic       tick_s;
    logic       left_press_s, right_press_s;
    logic       press_v_s;
    dir_t       press_d_s;
    logic [7:0] step_pos_s;

`ifdef MOVE_QUEUE_EN
    logic       q_valid_r, q_valid_nxt;
    dir_t       q_dir_r, q_dir_nxt;
    logic       req_v_s;
    dir_t       req_d_s;
`endif

    frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (ifc.Enable),
        .Tick   (tick_s)
    );

    // A simultaneous left+right press cancels both.
    assign left_press_s  = ifc.LeftIn  & ~left_q_r  & ~(ifc.RightIn & ~right_q_r);
    assign right_press_s = ifc.RightIn & ~right_q_r & ~(ifc.LeftIn  & ~left_q_r);
    assign press_v_s     = left_press_s | right_press_s;
    assign press_d_s     = left_press_s ? DIR_L : DIR_R;
    assign step_pos_s    = (dir_r == DIR_L) ? (pos_r - STEP_C) : (pos_r + STEP_C);

    // Key history; reset high so a key held through reset must be released first.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            left_q_r  <= 1'b1;
            right_q_r <= 1'b1;
        end else begin
            left_q_r  <= ifc.LeftIn;
            right_q_r <= ifc.RightIn;
        end
    end

    // Next-state logic: press handling, per-tick stepping and arrival.
    always_comb begin
        state_nxt   = state_r;
        dir_nxt     = dir_r;
        lane_nxt    = lane_r;
        target_nxt  = target_r;
        pos_nxt     = pos_r;
        done_nxt    = 1'b0;
        blocked_nxt = 1'b0;
`ifdef MOVE_QUEUE_EN
        q_valid_nxt = q_valid_r;
        q_dir_nxt   = q_dir_r;
        // A press in the arrival cycle itself supersedes an older queued one.
        req_v_s     = q_valid_r | press_v_s;
        req_d_s     = press_v_s ? press_d_s : q_dir_r;
`endif
        if (!ifc.Enable) begin
`ifdef MOVE_QUEUE_EN
            q_valid_nxt = 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (press_v_s) begin
                        if (can_move(lane_r, press_d_s, NUM_LANES)) begin
                            state_nxt  = MOVING;
                            dir_nxt    = press_d_s;
                            target_nxt = next_lane(lane_r, press_d_s);
                        end else begin
                            blocked_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                MOVING: begin
`ifdef MOVE_QUEUE_EN
                    q_valid_nxt = req_v_s;
                    q_dir_nxt   = req_d_s;
`endif
                    if (tick_s) begin
                        pos_nxt = step_pos_s;
                        if (step_pos_s == lane_x(target_r, X_ORIGIN, LANE_WIDTH)) begin
                            lane_nxt  = target_r;
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
`ifdef MOVE_QUEUE_EN
                            // Queued press is judged from the lane just reached.
                            q_valid_nxt = 1'b0;
                            if (req_v_s) begin
                                if (can_move(target_r, req_d_s, NUM_LANES)) begin
                                    state_nxt  = MOVING;
                                    dir_nxt    = req_d_s;
                                    target_nxt = next_lane(target_r, req_d_s);
                                end else begin
                                    blocked_nxt = 1'b1;
                                end
                            end else begin
                                state_nxt = IDLE;
                            end
`endif
                        end else begin
                            state_nxt = MOVING;
                        end
                    end else begin
                        state_nxt = MOVING;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, position and registered output pulses.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r   <= IDLE;
            dir_r     <= DIR_R;
            lane_r    <= START_LANE_C;
            target_r  <= START_LANE_C;
            pos_r     <= START_X_C;
            moving_r  <= 1'b0;
            done_r    <= 1'b0;
            blocked_r <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            dir_r     <= dir_nxt;
            lane_r    <= lane_nxt;
            target_r  <= target_nxt;
            pos_r     <= pos_nxt;
            moving_r  <= (state_nxt == MOVING);
            done_r    <= done_nxt;
            blocked_r <= blocked_nxt;
        end
    end

`ifdef MOVE_QUEUE_EN
    // One-entry press queue, live only during a move.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            q_valid_r <= 1'b0;
            q_dir_r   <= DIR_R;
        end else begin
            q_valid_r <= q_valid_nxt;
            q_dir_r   <= q_dir_nxt;
        end
    end
`endif

    assign ifc.Lane     = lane_r;
    assign ifc.PosX     = pos_r;
    assign ifc.Moving   = moving_r;
    assign ifc.MoveDone = done_r;
    assign ifc.Blocked  = blocked_r;

endmodule

// File: tb/tb_lane_move_controller.sv
// Self-checking bench for lane_move_controller (TICK_DIV=4, other defaults).
// A cycle-level reference model derived from the behavioural rules runs beside
// the DUT; directed scenarios are followed by a randomized key/enable/reset run.
module tb_lane_move_controller;
    localparam int N  = 4;
    localparam int SL = 1;
    localparam int XO = 16;
    localparam int W  = 40;
    localparam int ST = 4;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lane_move_controller_if ifc();

    lane_move_controller #(
        .NUM_LANES(N), .START_LANE(SL), .X_ORIGIN(XO),
        .LANE_WIDTH(W), .STEP_PX(ST), .TICK_DIV(TD)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .ifc   (ifc)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state (plain integers).
    int m_moving, m_lane, m_pos, m_tgt, m_dir, m_cnt;
    int m_pl, m_pr, m_qv, m_qd, m_done, m_blk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic try_move(input int d);
        int nt;
        nt = m_lane + d;
        if (nt >= 0 && nt < N) begin
            m_moving = 1; m_dir = d; m_tgt = nt;
        end else begin
            m_blk = 1;
        end
    endtask

    task automatic model_step();
        int  pl, pr;
        bit  tick;
        if (rst) begin
            m_moving = 0; m_lane = SL; m_pos = XO + SL * W; m_tgt = SL; m_dir = 1;
            m_cnt = 0; m_pl = 1; m_pr = 1; m_qv = 0; m_qd = 1; m_done = 0; m_blk = 0;
        end else begin
            pl = (ifc.LeftIn && !m_pl) ? 1 : 0;
            pr = (ifc.RightIn && !m_pr) ? 1 : 0;
            if (pl == 1 && pr == 1) begin pl = 0; pr = 0; end
            tick = ifc.Enable && (m_cnt == TD - 1);
            if (ifc.Enable) m_cnt = (m_cnt + 1) % TD;
            m_done = 0; m_blk = 0;
            if (!ifc.Enable) begin
                m_qv = 0;
            end else if (m_moving == 0) begin
                if (pl == 1 || pr == 1) try_move(pl == 1 ? -1 : 1);
            end else begin
`ifdef MOVE_QUEUE_EN
                if (pl == 1 || pr == 1) begin m_qv = 1; m_qd = (pl == 1) ? -1 : 1; end
`endif
                if (tick) begin
                    m_pos = m_pos + m_dir * ST;
                    if (m_pos == XO + m_tgt * W) begin
                        m_lane = m_tgt; m_done = 1; m_moving = 0;
                        if (m_qv == 1) begin try_move(m_qd); m_qv = 0; end
                    end
                end
            end
            m_pl = ifc.LeftIn ? 1 : 0;
            m_pr = ifc.RightIn ? 1 : 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("lane", 32'(ifc.Lane), 32'(m_lane));
        chk("posx", 32'(ifc.PosX), 32'(m_pos));
        chk("moving", 32'(ifc.Moving), 32'(m_moving));
        chk("movedone", 32'(ifc.MoveDone), 32'(m_done));
        chk("blocked", 32'(ifc.Blocked), 32'(m_blk));
    endtask

    task automatic press(input logic l, input logic r);
        ifc.LeftIn = l; ifc.RightIn = r;
        cycle();
        ifc.LeftIn = 1'b0; ifc.RightIn = 1'b0;
    endtask

    int dones;
    int k;

    initial begin
        ifc.Enable = 1'b1; ifc.LeftIn = 1'b0; ifc.RightIn = 1'b0;

        // 1: reset state
        rst = 1'b1;
        repeat (3) cycle();
        chk("rst_lane", 32'(ifc.Lane), 32'd1);
        chk("rst_posx", 32'(ifc.PosX), 32'd56);
        chk("rst_moving", 32'(ifc.Moving), 32'd0);
        chk("rst_pulses", 32'({ifc.MoveDone, ifc.Blocked}), 32'd0);
        rst = 1'b0;
        repeat (3) cycle();

        // 2: right move lane 1 -> 2
        press(1'b0, 1'b1);
        chk("t2_moving", 32'(ifc.Moving), 32'd1);
        dones = 0;
        repeat (50) begin cycle(); if (ifc.MoveDone === 1'b1) dones++; end
        chk("t2_dones", 32'(dones), 32'd1);
        chk("t2_lane", 32'(ifc.Lane), 32'd2);
        chk("t2_posx", 32'(ifc.PosX), 32'd96);

        // 3: walk to lane 0, then blocked left press
        repeat (2) begin press(1'b1, 1'b0); repeat (50) cycle(); end
        chk("t3_lane0", 32'(ifc.Lane), 32'd0);
        press(1'b1, 1'b0);
        chk("t3_blocked", 32'(ifc.Blocked), 32'd1);
        chk("t3_moving", 32'(ifc.Moving), 32'd0);
        cycle();
        chk("t3_blocked_end", 32'(ifc.Blocked), 32'd0);
        chk("t3_posx", 32'(ifc.PosX), 32'd16);

        // 4: back to lane 1, then simultaneous press is discarded
        press(1'b0, 1'b1); repeat (50) cycle();
        press(1'b1, 1'b1);
        chk("t4_moving", 32'(ifc.Moving), 32'd0);
        cycle();
        chk("t4_blocked", 32'(ifc.Blocked), 32'd0);
        repeat (20) cycle();
        chk("t4_lane", 32'(ifc.Lane), 32'd1);

        // 5: second right press during the move
        dones = 0;
        press(1'b0, 1'b1);
        repeat (12) cycle();
        press(1'b0, 1'b1);
        repeat (100) begin cycle(); if (ifc.MoveDone === 1'b1) dones++; end
`ifdef MOVE_QUEUE_EN
        chk("t5_lane", 32'(ifc.Lane), 32'd3);
        chk("t5_posx", 32'(ifc.PosX), 32'd136);
        chk("t5_dones", 32'(dones), 32'd2);
`else
        chk("t5_lane", 32'(ifc.Lane), 32'd2);
        chk("t5_posx", 32'(ifc.PosX), 32'd96);
        chk("t5_dones", 32'(dones), 32'd1);
`endif

        // 6: freeze mid-move at 72, resume, then reset mid-move
        rst = 1'b1; repeat (3) cycle(); rst = 1'b0; cycle();
        press(1'b0, 1'b1);
        for (int i = 0; i < 60 && m_pos != 72; i++) cycle();
        chk("t6_reach72", 32'(ifc.PosX), 32'd72);
        ifc.Enable = 1'b0;
        repeat (20) cycle();
        chk("t6_frozen", 32'(ifc.PosX), 32'd72);
        chk("t6_frozen_mv", 32'(ifc.Moving), 32'd1);
        ifc.Enable = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(); k++;
            if (ifc.MoveDone === 1'b1) break;
        end
        chk("t6_resume_cycles", 32'(k), 32'd24);
        chk("t6_posx", 32'(ifc.PosX), 32'd96);
        press(1'b0, 1'b1);
        repeat (10) cycle();
        rst = 1'b1;
        cycle();
        chk("t6_rst_lane", 32'(ifc.Lane), 32'd1);
        chk("t6_rst_posx", 32'(ifc.PosX), 32'd56);
        chk("t6_rst_done", 32'(ifc.MoveDone), 32'd0);
        chk("t6_rst_moving", 32'(ifc.Moving), 32'd0);
        repeat (2) cycle();
        rst = 1'b0;

        // Randomized keys, enable and occasional reset against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) ifc.LeftIn = ~ifc.LeftIn;
            if ($urandom_range(0, 7) == 0) ifc.RightIn = ~ifc.RightIn;
            if ($urandom_range(0, 29) == 0) ifc.Enable = ~ifc.Enable;
            rst = ($urandom_range(0, 399) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
